// File: rtl/rob_commit_if.sv
// ROB head-window bus between the reorder buffer and the commit stage.
// master = ROB side (drives slots/empty), slave = commit side (drives pop).
interface rob_commit_if #(
    parameter int DATA_W  = 32,
    parameter int ENTRY_W = 2*DATA_W+7
);
    logic [3:0]         slot_valid;
    logic [ENTRY_W-1:0] slot_data [4];
    logic               rob_empty;
    logic               consume;
    logic [1:0]         consume_count;

    modport master (
        output slot_valid,
        output slot_data,
        output rob_empty,
        input  consume,
        input  consume_count
    );

    modport slave (
        input  slot_valid,
        input  slot_data,
        input  rob_empty,
        output consume,
        output consume_count
    );
endinterface

// File: rtl/rob_commit.sv
// In-order commit stage: retires up to two ROB head entries per cycle.
// Ports: clock/reset_n, rob (slave bus), rf_* write ports, flush/epc, retired_count.
module rob_commit #(
    parameter int DATA_W  = 32,
    parameter int ENTRY_W = 2*DATA_W+7
) (
    input  logic              clock,
    input  logic              reset_n,
    rob_commit_if.slave       rob,
    output logic [1:0]        rf_we,
    output logic [4:0]        rf_waddr [2],
    output logic [DATA_W-1:0] rf_wdata [2],
    output logic              flush,
    output logic [DATA_W-1:0] epc,
    output logic [31:0]       retired_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_n;

    // Decoded fields of the two oldest slots
    logic              v0, v1;
    logic              x0, x1;
    logic              we0, we1;
    logic [4:0]        rd0, rd1;
    logic [DATA_W-1:0] res0, res1;
    logic [DATA_W-1:0] pc0, pc1;

    assign v0   = rob.slot_valid[0];
    assign v1   = rob.slot_valid[1];
    assign x0   = rob.slot_data[0][ENTRY_W-1];
    assign x1   = rob.slot_data[1][ENTRY_W-1];
    assign we0  = rob.slot_data[0][ENTRY_W-2];
    assign we1  = rob.slot_data[1][ENTRY_W-2];
    assign rd0  = rob.slot_data[0][ENTRY_W-3 -: 5];
    assign rd1  = rob.slot_data[1][ENTRY_W-3 -: 5];
    assign res0 = rob.slot_data[0][2*DATA_W-1:DATA_W];
    assign res1 = rob.slot_data[1][2*DATA_W-1:DATA_W];
    assign pc0  = rob.slot_data[0][DATA_W-1:0];
    assign pc1  = rob.slot_data[1][DATA_W-1:0];

    // Only the two oldest slots can commit; deeper slots are ignored
    logic unused_ok;
    assign unused_ok = ^{rob.slot_valid[3:2],
                         rob.slot_data[2],
                         rob.slot_data[3]};

    logic [1:0]        popped;
    logic [1:0]        n_commit;
    logic              go_exc;
    logic [DATA_W-1:0] exc_pc;

    always_comb begin
        popped   = 2'd0;
        n_commit = 2'd0;
        go_exc   = 1'b0;
        exc_pc   = '0;
        state_n  = state;
        unique case (state)
            RUN: begin
                if (v0 && x0) begin
                    popped = 2'd1;
                    go_exc = 1'b1;
                    exc_pc = pc0;
                end else if (v0 && v1 && x1) begin
                    // older entry retires, faulting one is dropped
                    popped   = 2'd2;
                    n_commit = 2'd1;
                    go_exc   = 1'b1;
                    exc_pc   = pc1;
                end else if (v0 && v1) begin
                    popped   = 2'd2;
                    n_commit = 2'd2;
                end else if (v0) begin
                    popped   = 2'd1;
                    n_commit = 2'd1;
                end
                if (go_exc) state_n = FLUSH;
            end
            FLUSH: state_n = DRAIN;
            DRAIN: if (rob.rob_empty) state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    assign rob.consume       = reset_n && (popped != 2'd0);
    assign rob.consume_count = (popped == 2'd0) ? 2'd0 : popped - 2'd1;

    // Port write enables; r0 writes are dropped
    logic wr0_raw, wr1, wr0;

    assign wr0_raw = (n_commit != 2'd0) && we0 && (rd0 != 5'd0);
    assign wr1     = (n_commit == 2'd2) && we1 && (rd1 != 5'd0);
    // Same rd on both ports: the younger result is the architectural one
    assign wr0     = wr0_raw && !(wr1 && (rd0 == rd1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_we       <= 2'b00;
            rf_waddr[0] <= '0;
            rf_waddr[1] <= '0;
            rf_wdata[0] <= '0;
            rf_wdata[1] <= '0;
        end else begin
            rf_we       <= {wr1, wr0};
            rf_waddr[0] <= wr0 ? rd0  : 5'd0;
            rf_wdata[0] <= wr0 ? res0 : '0;
            rf_waddr[1] <= wr1 ? rd1  : 5'd0;
            rf_wdata[1] <= wr1 ? res1 : '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flush         <= 1'b0;
            epc           <= '0;
            retired_count <= '0;
        end else begin
            flush         <= go_exc;
            retired_count <= retired_count + 32'(n_commit);
            if (go_exc) epc <= exc_pc;
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: window, gaps, hazards, exceptions, reset.
// Each step drives the ROB window and checks against hand-computed values.
module tb_rob_commit;

    localparam int DW = 32;
    localparam int EW = 2*DW+7;

    logic          clock;
    logic          reset_n;
    logic [1:0]    rf_we;
    logic [4:0]    rf_waddr [2];
    logic [DW-1:0] rf_wdata [2];
    logic          flush;
    logic [DW-1:0] epc;
    logic [31:0]   retired_count;

    int errors = 0;
    int checks = 0;

    rob_commit_if #(.DATA_W(DW)) bus ();

    rob_commit #(.DATA_W(DW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rob           (bus),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .flush         (flush),
        .epc           (epc),
        .retired_count (retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [EW-1:0] mk(
        input logic       exc,
        input logic       we,
        input logic [4:0] rd,
        input logic [31:0] res,
        input logic [31:0] pc
    );
        return {exc, we, rd, res, pc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_slots();
        bus.slot_valid = 4'b0000;
        for (int i = 0; i < 4; i++) bus.slot_data[i] = '0;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.rob_empty = 1'b0;
        clear_slots();
        bus.slot_valid[0] = 1'b1;
        bus.slot_data[0]  = mk(0, 1, 5'd3, 32'd1, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_consume", 32'(bus.consume), 0);
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_epc", epc, 0);
        chk("rst_retired", retired_count, 0);
        chk("rst_waddr0", 32'(rf_waddr[0]), 0);
        clear_slots();
        reset_n = 1'b1;
        settle();

        // Four-entry window, two per cycle
        bus.slot_valid   = 4'b1111;
        bus.slot_data[0] = mk(0, 1, 5'd1, 32'd10, 32'h100);
        bus.slot_data[1] = mk(0, 1, 5'd2, 32'd11, 32'h104);
        bus.slot_data[2] = mk(0, 1, 5'd3, 32'd12, 32'h108);
        bus.slot_data[3] = mk(0, 1, 5'd4, 32'd13, 32'h10c);
        settle();
        chk("win_consume", 32'(bus.consume), 1);
        chk("win_count", 32'(bus.consume_count), 1);
        step();
        bus.slot_data[0] = bus.slot_data[2];
        bus.slot_data[1] = bus.slot_data[3];
        bus.slot_valid   = 4'b0011;
        chk("win_we_a", 32'(rf_we), 3);
        chk("win_a0", 32'(rf_waddr[0]), 1);
        chk("win_d0", rf_wdata[0], 10);
        chk("win_a1", 32'(rf_waddr[1]), 2);
        chk("win_d1", rf_wdata[1], 11);
        chk("win_ret2", retired_count, 2);
        settle();
        chk("win_count2", 32'(bus.consume_count), 1);
        step();
        clear_slots();
        chk("win_we_b", 32'(rf_we), 3);
        chk("win_a0b", 32'(rf_waddr[0]), 3);
        chk("win_d0b", rf_wdata[0], 12);
        chk("win_a1b", 32'(rf_waddr[1]), 4);
        chk("win_d1b", rf_wdata[1], 13);
        chk("win_ret4", retired_count, 4);
        settle();
        chk("empty_consume", 32'(bus.consume), 0);
        step();
        chk("empty_we", 32'(rf_we), 0);
        chk("empty_ret", retired_count, 4);

        // Gap in the window
        bus.slot_valid   = 4'b0101;
        bus.slot_data[0] = mk(0, 1, 5'd6, 32'd20, 32'h200);
        bus.slot_data[2] = mk(0, 1, 5'd7, 32'd21, 32'h208);
        settle();
        chk("gap_consume", 32'(bus.consume), 1);
        chk("gap_count", 32'(bus.consume_count), 0);
        step();
        clear_slots();
        chk("gap_we", 32'(rf_we), 1);
        chk("gap_a0", 32'(rf_waddr[0]), 6);
        chk("gap_d0", rf_wdata[0], 20);
        chk("gap_ret", retired_count, 5);

        // r0 destination writes nothing
        bus.slot_valid   = 4'b0011;
        bus.slot_data[0] = mk(0, 1, 5'd0, 32'd99, 32'h300);
        bus.slot_data[1] = mk(0, 1, 5'd8, 32'd30, 32'h304);
        step();
        clear_slots();
        chk("r0_we", 32'(rf_we), 2);
        chk("r0_a1", 32'(rf_waddr[1]), 8);
        chk("r0_d1", rf_wdata[1], 30);
        chk("r0_ret", retired_count, 7);

        // Same rd on both ports
        bus.slot_valid   = 4'b0011;
        bus.slot_data[0] = mk(0, 1, 5'd5, 32'd7, 32'h400);
        bus.slot_data[1] = mk(0, 1, 5'd5, 32'd9, 32'h404);
        step();
        clear_slots();
        chk("haz_we", 32'(rf_we), 2);
        chk("haz_a1", 32'(rf_waddr[1]), 5);
        chk("haz_d1", rf_wdata[1], 9);
        chk("haz_ret", retired_count, 9);

        // Exception on slot 1
        bus.slot_valid   = 4'b0111;
        bus.slot_data[0] = mk(0, 1, 5'd9, 32'h55, 32'h3c);
        bus.slot_data[1] = mk(1, 1, 5'd10, 32'h66, 32'h40);
        bus.slot_data[2] = mk(0, 1, 5'd11, 32'h77, 32'h44);
        settle();
        chk("exc_consume", 32'(bus.consume), 1);
        chk("exc_count", 32'(bus.consume_count), 1);
        step();
        bus.slot_data[0] = bus.slot_data[2];
        bus.slot_valid   = 4'b0001;
        chk("exc_flush", 32'(flush), 1);
        chk("exc_epc", epc, 32'h40);
        chk("exc_we", 32'(rf_we), 1);
        chk("exc_a0", 32'(rf_waddr[0]), 9);
        chk("exc_ret", retired_count, 10);
        settle();
        chk("flush_consume", 32'(bus.consume), 0);
        step();
        chk("drain_flush", 32'(flush), 0);
        chk("drain_we", 32'(rf_we), 0);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("drain_hold", 32'(bus.consume), 0);
            step();
        end
        chk("drain_epc", epc, 32'h40);
        bus.rob_empty = 1'b1;
        clear_slots();
        settle();
        chk("drain_empty_consume", 32'(bus.consume), 0);
        step();
        bus.rob_empty    = 1'b0;
        bus.slot_valid   = 4'b0001;
        bus.slot_data[0] = mk(0, 1, 5'd11, 32'h77, 32'h500);
        settle();
        chk("resume_consume", 32'(bus.consume), 1);
        step();
        clear_slots();
        chk("resume_we", 32'(rf_we), 1);
        chk("resume_d0", rf_wdata[0], 32'h77);
        chk("resume_ret", retired_count, 11);

        // Exception on slot 0, then reset in DRAIN
        bus.slot_valid   = 4'b0011;
        bus.slot_data[0] = mk(1, 1, 5'd12, 32'h1, 32'h80);
        bus.slot_data[1] = mk(0, 1, 5'd13, 32'h2, 32'h84);
        settle();
        chk("exc0_count", 32'(bus.consume_count), 0);
        step();
        chk("exc0_flush", 32'(flush), 1);
        chk("exc0_epc", epc, 32'h80);
        chk("exc0_we", 32'(rf_we), 0);
        chk("exc0_ret", retired_count, 11);
        step();
        reset_n = 1'b0;
        settle();
        chk("rst2_consume", 32'(bus.consume), 0);
        chk("rst2_epc", epc, 0);
        chk("rst2_ret", retired_count, 0);
        chk("rst2_flush", 32'(flush), 0);
        step();
        reset_n          = 1'b1;
        clear_slots();
        bus.slot_valid   = 4'b0001;
        bus.slot_data[0] = mk(0, 1, 5'd12, 32'd5, 32'h600);
        settle();
        chk("post_rst_consume", 32'(bus.consume), 1);
        step();
        clear_slots();
        chk("post_rst_we", 32'(rf_we), 1);
        chk("post_rst_a0", 32'(rf_waddr[0]), 12);
        chk("post_rst_ret", retired_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
# rob_commit

In-order commit stage sitting directly downstream of the reorder buffer (`rob`). Each cycle it inspects the head window of ROB slots, retires up to two contiguous completed entries into the architectural register file, and pops them from the ROB via the consume handshake. An entry flagged with an exception stops commit: older entries retire, the faulting entry is dropped, a one-cycle pipeline flush is raised with the faulting PC, and the stage waits for the ROB to drain before resuming.

## Interface
- `DATA_W`, 32: result and PC width.
- `ENTRY_W`, 2*DATA_W+7: slot entry width. Fixed layout: [ENTRY_W-1]=exc, [ENTRY_W-2]=rd_we, [ENTRY_W-3 -: 5]=rd, [2*DATA_W-1:DATA_W]=result, [DATA_W-1:0]=pc.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `slot_valid[4]`  in  1 each  ROB head window; [0] is oldest.
- `slot_data[4]`  in  ENTRY_W each  entry contents matching `slot_valid`.
- `rob_empty`  in  1  ROB empty flag.
- `consume`  out  1  pop request to ROB, combinational.
- `consume_count`  out  2  entries popped minus one.
- `rf_we[2]`  out  1 each  register-file write enables; port 1 is younger.
- `rf_waddr[2]`  out  5 each  write addresses.
- `rf_wdata[2]`  out  DATA_W each  write data.
- `flush`  out  1  one-cycle pipeline flush pulse.
- `epc`  out  DATA_W  PC of the faulting entry.
- `retired_count`  out  32  running count of architecturally retired entries.

## Operation
- States: RUN, FLUSH, DRAIN. Reset state: RUN.
- RUN, window selection:
  - Let n = number of leading valid slots among [0],[1] (0..2).
  - Scan those n slots oldest-first for the first entry with exc=1, at index e.
  - No exception: commit all n entries.
  - Exception at e: commit slots [0..e-1], pop e+1 entries including the faulting one, latch its pc into `epc`, and go to FLUSH.
  - `consume` = (popped > 0); `consume_count` = popped-1.
- Commit of one entry: its write is issued on the matching port (oldest -> port 0) only if rd_we=1 and rd!=0.
- Same-cycle hazard: if both ports would write the same nonzero rd, port 0's write is suppressed. Only port 1 (the younger entry) writes.
- `retired_count` += number of committed entries, excluding the faulting entry. Wraps modulo 2^32.
- FLUSH: `flush`=1 for exactly this cycle, `consume`=0, no RF writes. Next state is DRAIN.
- DRAIN: `consume`=0. The stage leaves for RUN on the first cycle it samples `rob_empty`=1; the ROB clears itself on `flush`.
- A slot with valid=0 ends the window. Later valid slots are never committed out of order.

## Timing
- `consume`/`consume_count` are combinational from `slot_valid`/`slot_data` and state. The ROB pops at the same rising edge.
- `rf_we`/`rf_waddr`/`rf_wdata` are registered: asserted the cycle after the consume edge, for one cycle.
- `flush` is registered. It is high the cycle after the faulting entry is popped.
- `epc` is updated on that same edge and held until the next exception.
- Exception to resumed commit: at least 3 cycles (pop, FLUSH, DRAIN with rob_empty).
- Reset values: state RUN, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `flush`=0, `epc`=0, `retired_count`=0.
- `consume` is forced to 0 while `reset_n`=0.
- Reset asserted mid-FLUSH or mid-DRAIN returns to RUN immediately. Any pending registered writes are discarded.
- Empty window (slot_valid[0]=0): `consume`=0, no writes, counter unchanged.

## Test plan
- Window: slots 0..3 valid, rd=1,2,3,4, results 10,11,12,13. Required response:
  - Cycle 1: consume=1, count=1; next cycle rf writes (1,10),(2,11).
  - Then slots 2,3 retire on the following cycle.
  - `retired_count`=4.
- Gap: slot0 valid, slot1 invalid, slot2 valid -> consume_count=0; only port 0 writes.
- Register hazards:
  - r0 and matching rd: slot0 rd=0 writes nothing.
  - slot0/slot1 both rd=5, data 7/9 -> only port 1 writes r5=9.
- Exception:
  - slot1 exc=1, pc=0x40 -> pop 2 entries, slot0 committed, flush=1 one cycle later, epc=0x40, `retired_count` +1.
  - No consume until `rob_empty`=1.
- Drain hold: keep `rob_empty`=0 for 5 cycles after flush -> stage stays in DRAIN, consume=0 throughout; resumes RUN the cycle after empty=1.
- Reset mid-DRAIN: all outputs return to reset values. Commit of a fresh valid window proceeds normally after `reset_n` deasserts.
